// File: rtl/des_round_sequencer_if.sv
// Block-in / block-out handshake bundle for the iterative DES round sequencer.
// master = upstream/downstream side, slave = the sequencer.
interface des_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Iterative DES Feistel controller: one shared round per cycle, NUM_ROUNDS cycles per block,
// using an external f-function and subkey store selected through f_key_idx.
module des_round_sequencer #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  des_round_sequencer_if.slave   bus,
  output logic [31:0]            f_r,
  output logic [3:0]             f_key_idx,
  input  logic [31:0]            f_out,
  output logic                   busy
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] l_reg, l_next;
  logic [31:0] r_reg, r_next;
  logic [3:0]  rnd, rnd_next;
  logic        mode, mode_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      l_reg <= '0;
      r_reg <= '0;
      rnd   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_next;
      l_reg <= l_next;
      r_reg <= r_next;
      rnd   <= rnd_next;
      mode  <= mode_next;
    end
  end

  // f_out only reaches state in ROUND, so it is don't-care everywhere else.
  always_comb begin
    state_next    = state;
    l_next        = l_reg;
    r_next        = r_reg;
    rnd_next      = rnd;
    mode_next     = mode;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          l_next     = bus.in_data[63:32];
          r_next     = bus.in_data[31:0];
          mode_next  = bus.in_decrypt;
          rnd_next   = '0;
          state_next = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        l_next = r_reg;
        r_next = l_reg ^ f_out;
        if (rnd == LAST) begin
          state_next = DONE;
        end else begin
          rnd_next = rnd + 4'd1;
        end
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = {r_reg, l_reg};
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign f_r       = r_reg;
  assign f_key_idx = mode ? (LAST - rnd) : rnd;

endmodule
